ps2_mouse_packet_decoder: RTL and testbench
===========================================

# ps2_mouse_packet_decoder

Assembles the 3-byte PS/2 mouse movement packets delivered by the PS/2 byte receiver into per-packet motion and button values. Outputs are magnitude-plus-direction velocities, button state and a one-cycle ready strobe, formatted for the object-movement blocks: `vx` drives `vx`, `vy` drives `vy`, `dx`/`dy` drive `dx`/`dy`, `mousepush` drives `mousepush`, `mouseReady` drives `mouseReady`. Framing loss is handled by resynchronising on the packet's always-one bit and by an inter-byte timeout.

## Interface
Parameters:
- `SHIFT`, 0: right-shift applied to both magnitudes (sensitivity divider), range 0–8.
- `TIMEOUT`, 2000000: max idle cycles between bytes of one packet (20 ms at 100 MHz).
- `TW`, 21: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- `clk`  in  1  system clock; one clock domain; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rxData`  in  8  received PS/2 byte.
- `rxValid`  in  1  one-cycle strobe, `rxData` valid.
- `vx`  out  10  X speed magnitude, 0–256 before shift.
- `vy`  out  9  Y speed magnitude, 0–256 before shift.
- `dx`  out  1  X sign: 1 = negative (left).
- `dy`  out  1  Y sign: 1 = negative (PS/2 down).
- `mousepush`  out  1  left button held.
- `rbutton`  out  1  right button held.
- `mouseReady`  out  1  one-cycle pulse: new packet on outputs.
- `syncErr`  out  1  one-cycle pulse: byte discarded or packet aborted.

## Operation
- Packet byte 0 layout: [0] L, [1] R, [2] M (ignored), [3] always 1, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow. Byte 1 is X[7:0]; byte 2 is Y[7:0].
- FSM states:
  - `IDLE`: waiting for byte 0.
  - `B1`: waiting for byte 1.
  - `B2`: waiting for byte 2.
- Transitions:
  - In `IDLE`, `rxValid` with `rxData[3]`=1: latch byte 0, go to `B1`.
  - In `IDLE`, `rxValid` with `rxData[3]`=0: discard the byte, pulse `syncErr`, stay in `IDLE`.
  - In `B1`, `rxValid`: latch X byte, go to `B2`.
  - In `B2`, `rxValid`: update all outputs, pulse `mouseReady`, go to `IDLE`.
- Magnitude, computed per axis from the 9-bit two's-complement value {sign, byte}:
  - If sign = 0: mag = byte.
  - If sign = 1: mag = (~{sign, byte} + 1) taken as an unsigned 9/10-bit value. 0x100 with sign = 1 gives 256.
  - If the axis overflow bit is set: mag = 256, and the sign bit is still used for the direction.
  - Result = mag >> `SHIFT`, zero-extended to the output width.
- `dx`/`dy` are the raw sign bits, not inverted. Screen-Y convention is the consumer's concern.
- Timeout:
  - The counter is cleared on every accepted byte and counts only in `B1`/`B2`.
  - When the count reaches `TIMEOUT`: go to `IDLE`, pulse `syncErr`, keep outputs unchanged.
  - If `rxValid` arrives in the same cycle as expiry, the byte wins: it is accepted and there is no `syncErr`.
- Partial packets never modify the outputs. Outputs hold their values between packets.

## Timing
- Reset values: all outputs 0, state `IDLE`, counter 0, latched bytes 0.
- Reset asserted mid-packet: abandon the packet, zero all outputs, no pulses.
- Latency: all outputs are registered, and values change on the edge after the cycle in which byte 2's `rxValid` is sampled. `mouseReady` is high for exactly that one cycle.
- Consecutive `rxValid` on back-to-back cycles is accepted with no throughput limit, so a packet completes with a minimum of 3 strobes.
- `syncErr` is high for exactly one cycle per event. It never coincides with `mouseReady`.
- `rxValid` while `rst`=1 is ignored.

## Test plan
- Packet 0x09,0x05,0x00 -> `mouseReady` one cycle after the third byte; `mousepush`=1, `rbutton`=0, `vx`=5, `dx`=0, `vy`=0, `dy`=0.
- Packet 0x3A,0xFB,0xF0 -> `vx`=5, `dx`=1, `vy`=16, `dy`=1, `rbutton`=1, `mousepush`=0. With `SHIFT`=2: `vx`=1, `vy`=4.
- Overflow packets:
  - 0x48,0x10,0x00 -> `vx`=256, `dx`=0.
  - 0x18,0x00,0x00 -> `vx`=256, `dx`=1.
- Sync recovery: 0x05 alone -> `syncErr` pulse, outputs unchanged. Then 0x08,0x03,0x04 -> `vx`=3, `vy`=4, `mouseReady`.
- Timeout: 0x08,0x07, then idle for `TIMEOUT` cycles -> `syncErr`, no `mouseReady`. Then 0x08,0x01,0x02 decodes `vx`=1, `vy`=2.
- Reset after byte 1: all outputs 0 and no pulses. A following full packet decodes correctly; back-to-back strobes on consecutive cycles are decoded too.

Source files
------------

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte stream from the PS/2 receiver into the packet decoder, plus the decoded
// motion/button outputs consumed by the object-movement blocks.
interface ps2_mouse_packet_decoder_if;
    logic [7:0] rxData;
    logic       rxValid;
    logic [9:0] vx;
    logic [8:0] vy;
    logic       dx;
    logic       dy;
    logic       mousepush;
    logic       rbutton;
    logic       mouseReady;
    logic       syncErr;

    modport master (
        output rxData, rxValid,
        input  vx, vy, dx, dy, mousepush, rbutton, mouseReady, syncErr
    );

    modport slave (
        input  rxData, rxValid,
        output vx, vy, dx, dy, mousepush, rbutton, mouseReady, syncErr
    );
endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into magnitude+sign velocities and buttons,
// resynchronising on the header's always-one bit and aborting stalled packets.
module ps2_mouse_packet_decoder #(
    parameter int SHIFT   = 0,
    parameter int TIMEOUT = 2000000,
    parameter int TW      = 21
) (
    input logic clk,
    input logic rst,
    ps2_mouse_packet_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, B1, B2} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] cnt;
    // header fields kept: [0] L, [1] R, [2] X sign, [3] Y sign, [4] X ovf, [5] Y ovf
    logic [5:0]    hdr;
    logic [7:0]    bx;
    logic          take_hdr, take_x, done, err, expired;
    logic [8:0]    mag_x, mag_y;

    function automatic logic [8:0] mag(input logic s, input logic ov, input logic [7:0] b);
        logic [8:0] v;
        v = {s, b};
        if (ov)     return 9'h100;
        else if (s) return ~v + 9'd1;
        else        return {1'b0, b};
    endfunction

    assign expired = (state != IDLE) && (cnt == TW'(TIMEOUT));
    assign mag_x   = mag(hdr[2], hdr[4], bx);
    assign mag_y   = mag(hdr[3], hdr[5], bus.rxData);

    always_comb begin
        state_nxt = state;
        take_hdr  = 1'b0;
        take_x    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: if (bus.rxValid) begin
                if (bus.rxData[3]) begin
                    take_hdr  = 1'b1;
                    state_nxt = B1;
                end else begin
                    err = 1'b1;
                end
            end
            B1: if (bus.rxValid) begin
                take_x    = 1'b1;
                state_nxt = B2;
            end else if (expired) begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            B2: if (bus.rxValid) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end else if (expired) begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            hdr            <= '0;
            bx             <= '0;
            bus.vx         <= '0;
            bus.vy         <= '0;
            bus.dx         <= 1'b0;
            bus.dy         <= 1'b0;
            bus.mousepush  <= 1'b0;
            bus.rbutton    <= 1'b0;
            bus.mouseReady <= 1'b0;
            bus.syncErr    <= 1'b0;
        end else begin
            state <= state_nxt;
            // an accepted byte restarts the idle count; it only runs mid-packet
            cnt   <= (state_nxt == IDLE || bus.rxValid) ? '0 : cnt + TW'(1);
            if (take_hdr) hdr <= {bus.rxData[7:4], bus.rxData[1:0]};
            if (take_x)   bx  <= bus.rxData;
            bus.mouseReady <= done;
            bus.syncErr    <= err;
            if (done) begin
                bus.vx        <= 10'(mag_x >> SHIFT);
                bus.vy        <= 9'(mag_y >> SHIFT);
                bus.dx        <= hdr[2];
                bus.dy        <= hdr[3];
                bus.mousepush <= hdr[0];
                bus.rbutton   <= hdr[1];
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Drives the decoder (SHIFT=0 and SHIFT=2 copies) with directed packets and checks
// every cycle against a queue-based packet model plus hand-computed literals.
module tb_ps2_mouse_packet_decoder;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         armed = 1'b0;

    always #5 clk = ~clk;

    ps2_mouse_packet_decoder_if bus0();
    ps2_mouse_packet_decoder_if bus2();
    assign bus0.rxData = data;
    assign bus0.rxValid = valid;
    assign bus2.rxData = data;
    assign bus2.rxValid = valid;

    ps2_mouse_packet_decoder #(.SHIFT(0), .TIMEOUT(TO), .TW(5)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ps2_mouse_packet_decoder #(.SHIFT(2), .TIMEOUT(TO), .TW(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // ---------------- model ----------------
    logic [7:0] q[$];
    int   idle = 0;
    int   e_vx0 = 0, e_vy0 = 0, e_vx2 = 0, e_vy2 = 0;
    logic e_dx = 0, e_dy = 0, e_l = 0, e_r = 0, e_rdy = 0, e_err = 0;

    function automatic int mag(input logic s, input logic ov, input logic [7:0] b, input int sh);
        int v;
        v = s ? int'(b) - 256 : int'(b);
        if (ov) v = 256;
        else if (v < 0) v = -v;
        return v >> sh;
    endfunction

    task automatic model_step();
        logic [7:0] h, x;
        e_rdy = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            q.delete(); idle = 0;
            e_vx0 = 0; e_vy0 = 0; e_vx2 = 0; e_vy2 = 0;
            e_dx = 0; e_dy = 0; e_l = 0; e_r = 0;
        end else if (valid) begin
            idle = 0;
            if (q.size() == 0) begin
                if (data[3]) q.push_back(data);
                else e_err = 1'b1;
            end else if (q.size() == 1) begin
                q.push_back(data);
            end else begin
                h = q[0]; x = q[1];
                e_vx0 = mag(h[4], h[6], x, 0);
                e_vy0 = mag(h[5], h[7], data, 0);
                e_vx2 = mag(h[4], h[6], x, 2);
                e_vy2 = mag(h[5], h[7], data, 2);
                e_dx = h[4]; e_dy = h[5]; e_l = h[0]; e_r = h[1];
                e_rdy = 1'b1;
                q.delete();
            end
        end else if (q.size() != 0) begin
            if (idle == TO) begin
                e_err = 1'b1; q.delete(); idle = 0;
            end else begin
                idle++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) if (armed) begin
        chk("vx0", bus0.vx, e_vx0);       chk("vy0", bus0.vy, e_vy0);
        chk("vx2", bus2.vx, e_vx2);       chk("vy2", bus2.vy, e_vy2);
        chk("dx", bus0.dx, e_dx);         chk("dy", bus0.dy, e_dy);
        chk("push", bus0.mousepush, e_l); chk("rbtn", bus0.rbutton, e_r);
        chk("ready", bus0.mouseReady, e_rdy); chk("err", bus0.syncErr, e_err);
        chk("ready2", bus2.mouseReady, e_rdy); chk("err2", bus2.syncErr, e_err);
        chk("dx2", bus2.dx, e_dx);        chk("push2", bus2.mousepush, e_l);
    end

    task automatic cyc(input logic v, input logic [7:0] d);
        valid = v; data = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int gap);
        cyc(1, a);
        for (int i = 0; i < gap; i++) cyc(0, 8'h00);
        cyc(1, b);
        for (int i = 0; i < gap; i++) cyc(0, 8'h00);
        cyc(1, c);
    endtask

    initial begin
        int errs, rdys;
        rst = 1'b1;
        cyc(0, 0); cyc(0, 0);
        armed = 1'b1;
        chk("rst_vx", bus0.vx, 0);
        chk("rst_ready", bus0.mouseReady, 0);
        chk("rst_err", bus0.syncErr, 0);
        rst = 1'b0;
        cyc(0, 0);

        pkt(8'h09, 8'h05, 8'h00, 0);
        chk("p1_ready", bus0.mouseReady, 1);
        chk("p1_push", bus0.mousepush, 1);
        chk("p1_rbtn", bus0.rbutton, 0);
        chk("p1_vx", bus0.vx, 5);
        chk("p1_dx", bus0.dx, 0);
        chk("p1_vy", bus0.vy, 0);
        cyc(0, 0);
        chk("p1_ready_drop", bus0.mouseReady, 0);

        pkt(8'h3A, 8'hFB, 8'hF0, 2);
        chk("p2_vx", bus0.vx, 5);   chk("p2_dx", bus0.dx, 1);
        chk("p2_vy", bus0.vy, 16);  chk("p2_dy", bus0.dy, 1);
        chk("p2_rbtn", bus0.rbutton, 1); chk("p2_push", bus0.mousepush, 0);
        chk("p2_vx_s2", bus2.vx, 1); chk("p2_vy_s2", bus2.vy, 4);
        cyc(0, 0);

        pkt(8'h48, 8'h10, 8'h00, 1);
        chk("ovf_pos_vx", bus0.vx, 256); chk("ovf_pos_dx", bus0.dx, 0);
        chk("ovf_pos_vx_s2", bus2.vx, 64);
        pkt(8'h18, 8'h00, 8'h00, 0);
        chk("neg256_vx", bus0.vx, 256); chk("neg256_dx", bus0.dx, 1);
        pkt(8'h88, 8'h01, 8'h02, 0);
        chk("ovf_y_vy", bus0.vy, 256); chk("ovf_y_vx", bus0.vx, 1);
        cyc(0, 0);

        cyc(1, 8'h05);
        chk("sync_err", bus0.syncErr, 1);
        chk("sync_keep_vy", bus0.vy, 256);
        pkt(8'h08, 8'h03, 8'h04, 0);
        chk("sync_ready", bus0.mouseReady, 1);
        chk("sync_vx", bus0.vx, 3); chk("sync_vy", bus0.vy, 4);

        // stalled packet: abort after the idle limit, outputs held
        cyc(1, 8'h08); cyc(1, 8'h07);
        errs = 0; rdys = 0;
        for (int i = 0; i < TO + 3; i++) begin
            cyc(0, 0);
            errs += int'(bus0.syncErr); rdys += int'(bus0.mouseReady);
        end
        chk("to_err_count", errs, 1); chk("to_ready_count", rdys, 0);
        chk("to_keep_vx", bus0.vx, 3);
        pkt(8'h08, 8'h01, 8'h02, 0);
        chk("to_after_vx", bus0.vx, 1); chk("to_after_vy", bus0.vy, 2);

        // byte arriving exactly on the expiry cycle is accepted
        cyc(1, 8'h08);
        for (int i = 0; i < TO; i++) cyc(0, 0);
        errs = 0;
        cyc(1, 8'h05); errs += int'(bus0.syncErr);
        cyc(1, 8'h06); errs += int'(bus0.syncErr);
        chk("edge_no_err", errs, 0);
        chk("edge_ready", bus0.mouseReady, 1);
        chk("edge_vx", bus0.vx, 5); chk("edge_vy", bus0.vy, 6);

        // reset mid-packet, with a strobe during reset that must be ignored
        cyc(1, 8'h08); cyc(1, 8'h09);
        rst = 1'b1;
        cyc(1, 8'h0A);
        chk("mid_rst_vx", bus0.vx, 0); chk("mid_rst_vy", bus0.vy, 0);
        chk("mid_rst_ready", bus0.mouseReady, 0); chk("mid_rst_err", bus0.syncErr, 0);
        rst = 1'b0;
        pkt(8'h09, 8'h0A, 8'h0B, 0);
        chk("post_rst_vx", bus0.vx, 10); chk("post_rst_vy", bus0.vy, 11);
        chk("post_rst_push", bus0.mousepush, 1);
        pkt(8'h38, 8'h80, 8'h7F, 0);
        chk("b2b_vx", bus0.vx, 128); chk("b2b_vy", bus0.vy, 129);
        chk("b2b_dx", bus0.dx, 1); chk("b2b_dy", bus0.dy, 1);
        chk("b2b_vx_s2", bus2.vx, 32); chk("b2b_vy_s2", bus2.vy, 32);
        cyc(0, 0); cyc(0, 0);

        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
